// File: rtl/latch_strobe_gen.sv
// Sequences d/en/s/r strobes for transparent and set/reset latch banks behind a valid/ready request port.
// Optional readback compare of the latch outputs: define LATCH_STROBE_READBACK_EN.
module latch_strobe_gen #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic [WIDTH-1:0] d_o,
    output logic             en_o,
    output logic             s_o,
    output logic             r_o,
    output logic             busy,
    output logic             done
`ifdef LATCH_STROBE_READBACK_EN
    ,
    input  logic [WIDTH-1:0] q_fb,
    output logic             err
`endif
);

    localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'((PULSE_CYC > 0) ? PULSE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    if (PULSE_CYC < 1) begin : g_bad_pulse
        $error("latch_strobe_gen: PULSE_CYC must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op;

    // One-hot strobe pattern {en, s, r} for an op; nop drives none.
    function automatic logic [2:0] strobes(input logic [1:0] o);
        case (o)
            OP_LOAD:  strobes = 3'b100;
            OP_SET:   strobes = 3'b010;
            OP_CLEAR: strobes = 3'b001;
            default:  strobes = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            op                 <= OP_NOP;
            d_o                <= '0;
            {en_o, s_o, r_o}   <= 3'b000;
            busy               <= 1'b0;
            done               <= 1'b0;
            req_ready          <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op        <= req_op;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        if (req_op == OP_LOAD) d_o <= req_data;
                        if (SETUP_CYC > 0) begin
                            state <= SETUP;
                            cnt   <= SETUP_LD;
                        end else begin
                            state            <= PULSE;
                            cnt              <= PULSE_LD;
                            {en_o, s_o, r_o} <= strobes(req_op);
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state            <= PULSE;
                        cnt              <= PULSE_LD;
                        {en_o, s_o, r_o} <= strobes(op);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        {en_o, s_o, r_o} <= 3'b000;
                        if (HOLD_CYC > 0) begin
                            state <= HOLD;
                            cnt   <= HOLD_LD;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            done      <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LATCH_STROBE_READBACK_EN
    logic             chk_pt;
    logic [WIDTH-1:0] q_exp;

    // Compare on the final cycle before done, i.e. the last HOLD cycle or last PULSE cycle.
    assign chk_pt = (cnt == '0) &&
                    ((state == HOLD) || ((HOLD_CYC == 0) && (state == PULSE)));

    always_comb begin
        q_exp = '0;
        case (op)
            OP_LOAD: q_exp = d_o;
            OP_SET:  q_exp = '1;
            default: q_exp = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (chk_pt && (op != OP_NOP) && (q_fb != q_exp)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_latch_strobe_gen.sv
// Scoreboard bench for latch_strobe_gen: DUT a uses default timing, DUT b uses SETUP=0/PULSE=1/HOLD=0.
module tb_latch_strobe_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       valid_a, ready_a, en_a, s_a, r_a, busy_a, done_a;
    logic [1:0] op_a;
    logic [7:0] data_a, d_a;
    logic       valid_b, ready_b, en_b, s_b, r_b, busy_b, done_b;
    logic [1:0] op_b;
    logic [7:0] data_b, d_b;
    bit         force_a, force_b;

`ifdef LATCH_STROBE_READBACK_EN
    logic [7:0] q_fb_a, q_fb_b, lat_a, lat_b;
    logic       err_a, err_b;
    // Behavioural latch banks: transparent while a strobe is high, holding otherwise.
    always @(posedge clk) begin
        lat_a <= en_a ? d_a : s_a ? 8'hFF : r_a ? 8'h00 : lat_a;
        lat_b <= en_b ? d_b : s_b ? 8'hFF : r_b ? 8'h00 : lat_b;
    end
    assign q_fb_a = force_a ? 8'h00 : (en_a ? d_a : s_a ? 8'hFF : r_a ? 8'h00 : lat_a);
    assign q_fb_b = force_b ? 8'h00 : (en_b ? d_b : s_b ? 8'hFF : r_b ? 8'h00 : lat_b);
`endif

    latch_strobe_gen #(.WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a), .req_op(op_a),
        .req_data(data_a), .d_o(d_a), .en_o(en_a), .s_o(s_a), .r_o(r_a),
        .busy(busy_a), .done(done_a)
`ifdef LATCH_STROBE_READBACK_EN
        , .q_fb(q_fb_a), .err(err_a)
`endif
    );

    latch_strobe_gen #(.WIDTH(8), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b), .req_op(op_b),
        .req_data(data_b), .d_o(d_b), .en_o(en_b), .s_o(s_b), .r_o(r_b),
        .busy(busy_b), .done(done_b)
`ifdef LATCH_STROBE_READBACK_EN
        , .q_fb(q_fb_b), .err(err_b)
`endif
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] d;
        int         acc;
        bit         frc;
    } item_t;

    item_t      qa[$], qb[$];
    logic [7:0] last_a, last_b;
    bit         errm_a, errm_b;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected {done, busy, ready, en, s, r} at cycle rel after acceptance.
    function automatic logic [5:0] exp_vec(input logic [1:0] op, input int rel,
                                           input int sc, input int pc, input int hc);
        logic st;
        st = (rel >= sc + 1) && (rel <= sc + pc);
        if (rel == sc + pc + hc + 1) return 6'b101000;
        return {3'b010, st && op == 2'b00, st && op == 2'b01, st && op == 2'b10};
    endfunction

    function automatic logic [7:0] q_expect(input item_t it);
        return (it.op == 2'b00) ? it.d : (it.op == 2'b01) ? 8'hFF : 8'h00;
    endfunction

    always @(negedge clk) begin : mon_a
        item_t it;
        int    rel;
        if (rst) begin
            qa.delete();
            errm_a = 1'b0;
        end else begin
            check("excl_a", 32'({en_a & s_a, en_a & r_a, s_a & r_a}), 32'(0));
            if (qa.size() == 0) begin
                check("idle_a", 32'({done_a, busy_a, ready_a, en_a, s_a, r_a}), 32'(6'b001000));
            end else begin
                it  = qa[0];
                rel = cyc - it.acc;
                if (rel > 0) begin
                    check("out_a", 32'({done_a, busy_a, ready_a, en_a, s_a, r_a}),
                          32'(exp_vec(it.op, rel, 1, 2, 1)));
                    check("d_a", 32'(d_a), 32'(it.d));
                end
                if (rel >= 5) begin
`ifdef LATCH_STROBE_READBACK_EN
                    if (it.frc && it.op != 2'b11 && q_expect(it) != 8'h00) errm_a = 1'b1;
                    check("err_a", 32'(err_a), 32'(errm_a));
`endif
                    void'(qa.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        item_t it;
        int    rel;
        if (rst) begin
            qb.delete();
            errm_b = 1'b0;
        end else begin
            check("excl_b", 32'({en_b & s_b, en_b & r_b, s_b & r_b}), 32'(0));
            if (qb.size() == 0) begin
                check("idle_b", 32'({done_b, busy_b, ready_b, en_b, s_b, r_b}), 32'(6'b001000));
            end else begin
                it  = qb[0];
                rel = cyc - it.acc;
                if (rel > 0) begin
                    check("out_b", 32'({done_b, busy_b, ready_b, en_b, s_b, r_b}),
                          32'(exp_vec(it.op, rel, 0, 1, 0)));
                    check("d_b", 32'(d_b), 32'(it.d));
                end
                if (rel >= 2) begin
`ifdef LATCH_STROBE_READBACK_EN
                    if (it.frc && it.op != 2'b11 && q_expect(it) != 8'h00) errm_b = 1'b1;
                    check("err_b", 32'(err_b), 32'(errm_b));
`endif
                    void'(qb.pop_front());
                end
            end
        end
    end

    // Called at a negedge; leaves valid high so a following call chains back-to-back.
    task automatic send(input int w, input logic [1:0] op, input logic [7:0] data);
        int n;
        item_t it;
        n = 0;
        if (w == 0) begin
            valid_a = 1'b1; op_a = op; data_a = data;
            while (!ready_a && n < 40) begin @(negedge clk); n++; end
            check("ready_wait_a", 32'(ready_a), 32'(1));
            it = '{op: op, d: (op == 2'b00) ? data : last_a, acc: cyc, frc: force_a};
            if (op == 2'b00) last_a = data;
            qa.push_back(it);
            @(negedge clk);
            data_a = 8'($urandom); op_a = 2'($urandom);
        end else begin
            valid_b = 1'b1; op_b = op; data_b = data;
            while (!ready_b && n < 40) begin @(negedge clk); n++; end
            check("ready_wait_b", 32'(ready_b), 32'(1));
            it = '{op: op, d: (op == 2'b00) ? data : last_b, acc: cyc, frc: force_b};
            if (op == 2'b00) last_b = data;
            qb.push_back(it);
            @(negedge clk);
            data_b = 8'($urandom); op_b = 2'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin @(negedge clk); n++; end
        check("drain", 32'(qa.size() + qb.size()), 32'(0));
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_out_a", 32'({done_a, busy_a, ready_a, en_a, s_a, r_a}), 32'(6'b001000));
        check("rst_d_a", 32'(d_a), 32'(0));
        repeat (2) begin
            @(negedge clk);
            check("rst_done_a", 32'(done_a), 32'(0));
        end
        last_a = 8'h00;
        last_b = 8'h00;
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        valid_a = 1'b0; op_a = 2'b11; data_a = 8'h00;
        valid_b = 1'b0; op_b = 2'b11; data_b = 8'h00;
        force_a = 1'b0; force_b = 1'b0;
        last_a = 8'h00; last_b = 8'h00;
        #3;
        check("reset_a", 32'({done_a, busy_a, ready_a, en_a, s_a, r_a, d_a}), 32'({6'b001000, 8'h00}));
        check("reset_b", 32'({done_b, busy_b, ready_b, en_b, s_b, r_b, d_b}), 32'({6'b001000, 8'h00}));
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        send(0, 2'b00, 8'hA5); drain();
        send(0, 2'b11, 8'h5A); drain();
        send(0, 2'b01, 8'h00); send(0, 2'b10, 8'hFF); drain();
        send(1, 2'b00, 8'h3C); drain();
        send(1, 2'b00, 8'hC3); send(1, 2'b11, 8'h11); send(1, 2'b01, 8'h22); drain();

        send(0, 2'b00, 8'h96);
        valid_a = 1'b0;
        @(negedge clk);
        check("pre_rst_en_a", 32'(en_a), 32'(1));
        pulse_reset();
        send(0, 2'b10, 8'h00); drain();

`ifdef LATCH_STROBE_READBACK_EN
        force_a = 1'b1;
        send(0, 2'b01, 8'h00); drain();
        force_a = 1'b0;
        send(0, 2'b00, 8'h5A); send(0, 2'b10, 8'h00); drain();
        check("err_sticky_a", 32'(err_a), 32'(1));
        check("err_b_clean", 32'(err_b), 32'(0));
        @(negedge clk);
        pulse_reset();
        check("err_cleared_a", 32'(err_a), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
